// File: rtl/key_spi_pkg.sv
// key_spi_pkg: shared defaults and state encoding for the keypad-to-SPI scheduler.
//   DEF_DATA_W / DEF_DEPTH / DEF_CS_SETUP / DEF_CS_HOLD : default parameter values
//   ST_IDLE..ST_HOLD : 3-bit state encodings, wrapped by state_e
package key_spi_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_CS_SETUP = 2;
    localparam int unsigned DEF_CS_HOLD  = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_XFER  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        START = ST_START,
        XFER  = ST_XFER,
        HOLD  = ST_HOLD
    } state_e;

endpackage

// File: rtl/key_spi_fifo.sv
// key_spi_fifo: synchronous FIFO for key codes.
//   clk, rst        : clock, synchronous active-high reset (flushes pointers)
//   push, push_data : write request and data
//   pop             : read request; head is the current head entry
//   full, empty     : registered status, updated on the same edge as the pointers
module key_spi_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              do_push_c, do_pop_c;

    // A pop on a full FIFO frees a slot, so a simultaneous push is accepted.
    always_comb begin
        do_pop_c  = pop && !empty_q;
        do_push_c = push && (!full_q || do_pop_c);
        wr_ptr_d  = wr_ptr_q + (AW+1)'(do_push_c);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(do_pop_c);
        empty_d   = (wr_ptr_d == rd_ptr_d);
        full_d    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/key_spi_sched.sv
// key_spi_sched: queues key codes and sequences one SPI transaction per code
// (chip-select setup, start pulse, wait for done, chip-select hold, idle gap).
//   clk, rst              : clock, synchronous active-high reset
//   key_valid, key_data   : one-cycle push of a key code
//   spi_start, spi_data   : start pulse and word to the SPI master
//   spi_busy, spi_done    : SPI master status
//   cs_n                  : slave chip select, active low
//   fifo_full, fifo_empty : FIFO status
//   ovf_cnt               : saturating dropped-code counter, only with KEY_SPI_OVF_CNT_EN
module key_spi_sched
    import key_spi_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned CS_SETUP = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD  = DEF_CS_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_data,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    input  logic              spi_busy,
    input  logic              spi_done,
    output logic              cs_n,
`ifdef KEY_SPI_OVF_CNT_EN
    output logic [7:0]        ovf_cnt,
`endif
    output logic              fifo_full,
    output logic              fifo_empty
);

    localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cs_n_q, cs_n_d;
    logic              spi_start_q, spi_start_d;
    logic [DATA_W-1:0] spi_data_q, spi_data_d;
    logic              pop_c;
    logic [DATA_W-1:0] head;

    key_spi_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (key_valid),
        .push_data (key_data),
        .pop       (pop_c),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and registered-output logic. The counter holds remaining-1,
    // so a phase of N cycles ends when it reads zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_n_d      = cs_n_q;
        spi_start_d = 1'b0;
        spi_data_d  = spi_data_q;
        pop_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !spi_busy) begin
                    pop_c      = 1'b1;
                    spi_data_d = head;
                    cs_n_d     = 1'b0;
                    cnt_d      = CNT_W'(CS_SETUP - 1);
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    spi_start_d = 1'b1;
                    state_d     = START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            START: begin
                state_d = XFER;
            end
            XFER: begin
                if (spi_done) begin
                    cnt_d   = CNT_W'(CS_HOLD - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cs_n_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs_n_q      <= cs_n_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
        end
    end

    assign cs_n      = cs_n_q;
    assign spi_start = spi_start_q;
    assign spi_data  = spi_data_q;

`ifdef KEY_SPI_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // A push is dropped only when full and not relieved by a same-cycle pop.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (key_valid && fifo_full && !pop_c && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
